// File: rtl/obi_bank_arbiter_if.sv
// ---------------------------------------------------------------------------
// obi_bank_arbiter_if
//   Bundles the OBI master-side and bank-side signals of the bank arbiter.
//
//   Master side (one entry per master):
//     master_req / master_we / master_addr / master_wdata / master_be  (request)
//     master_gnt / master_rvalid / master_rdata                        (response)
//   Bank side (one entry per bank):
//     bank_req / bank_we / bank_addr / bank_wdata / bank_be            (request)
//     bank_gnt / bank_rvalid / bank_rdata                              (response)
//
//   Modports:
//     slave  - the arbiter: consumes master requests and bank responses,
//              produces master responses and bank requests.
//     master - the environment around the arbiter (masters + banks).
// ---------------------------------------------------------------------------
interface obi_bank_arbiter_if #(
  parameter int NUM_MASTERS = 2,
  parameter int NUM_BANKS   = 2
);

  // Master requests
  logic [NUM_MASTERS-1:0]       master_req;
  logic [NUM_MASTERS-1:0]       master_we;
  logic [NUM_MASTERS-1:0][31:0] master_addr;
  logic [NUM_MASTERS-1:0][31:0] master_wdata;
  logic [NUM_MASTERS-1:0][3:0]  master_be;
  // Master responses
  logic [NUM_MASTERS-1:0]       master_gnt;
  logic [NUM_MASTERS-1:0]       master_rvalid;
  logic [NUM_MASTERS-1:0][31:0] master_rdata;

  // Bank requests
  logic [NUM_BANKS-1:0]         bank_req;
  logic [NUM_BANKS-1:0]         bank_we;
  logic [NUM_BANKS-1:0][31:0]   bank_addr;
  logic [NUM_BANKS-1:0][31:0]   bank_wdata;
  logic [NUM_BANKS-1:0][3:0]    bank_be;
  // Bank responses
  logic [NUM_BANKS-1:0]         bank_gnt;
  logic [NUM_BANKS-1:0]         bank_rvalid;
  logic [NUM_BANKS-1:0][31:0]   bank_rdata;

  modport slave (
    input  master_req, master_we, master_addr, master_wdata, master_be,
    output master_gnt, master_rvalid, master_rdata,
    output bank_req, bank_we, bank_addr, bank_wdata, bank_be,
    input  bank_gnt, bank_rvalid, bank_rdata
  );

  modport master (
    output master_req, master_we, master_addr, master_wdata, master_be,
    input  master_gnt, master_rvalid, master_rdata,
    input  bank_req, bank_we, bank_addr, bank_wdata, bank_be,
    output bank_gnt, bank_rvalid, bank_rdata
  );

endinterface

// File: rtl/obi_bank_arbiter.sv
// ---------------------------------------------------------------------------
// obi_bank_arbiter
//   Shares NUM_BANKS single-port SRAM banks between NUM_MASTERS OBI masters.
//   Every master request is decoded to a bank from
//   addr[BANK_LSB +: log2(NUM_BANKS)]; each bank runs its own round-robin
//   arbiter. Grants are combinational (same cycle as the request); the read
//   response of a bank, one cycle after its grant, is steered back to the
//   master that owned that grant.
//
//   Ports:
//     clk_i          clock
//     rst_i          synchronous, active-high reset
//     bus            obi_bank_arbiter_if.slave (master requests/responses,
//                    bank requests/responses)
//     cnt_clear_i    clears all conflict counters      (optional feature)
//     conflict_cnt_o NUM_BANKS x CNT_W conflict counts (optional feature)
//
//   Optional feature macro: OBI_ARB_CONFLICT_CNT_EN
//     When defined, each bank gets a saturating CNT_W-bit counter of cycles
//     in which two or more masters targeted it. Without it the counter ports
//     and logic are absent.
// ---------------------------------------------------------------------------
module obi_bank_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int NUM_BANKS   = 2,
  parameter int BANK_LSB    = 15,
  parameter int CNT_W       = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  obi_bank_arbiter_if.slave          bus
`ifdef OBI_ARB_CONFLICT_CNT_EN
  ,
  input  logic                       cnt_clear_i,
  output logic [NUM_BANKS*CNT_W-1:0] conflict_cnt_o
`endif
);

  localparam int BANK_W = (NUM_BANKS > 1)   ? $clog2(NUM_BANKS)   : 1;
  localparam int MIDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  // Elaboration-time sanity check on the configuration.
  if ((NUM_MASTERS < 1) || (NUM_BANKS < 1) ||
      ((NUM_BANKS & (NUM_BANKS - 1)) != 0) || (CNT_W < 1)) begin : g_param_err
    $error("obi_bank_arbiter: illegal parameter combination");
  end

  // ---------------------------------------------------------------------
  // Bank decode per master
  // ---------------------------------------------------------------------
  logic [BANK_W-1:0] bank_sel [NUM_MASTERS];

  for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_decode
    if (NUM_BANKS > 1) begin : g_multi
      assign bank_sel[gi] = bus.master_addr[gi][BANK_LSB +: BANK_W];
    end else begin : g_single
      assign bank_sel[gi] = '0;
    end
  end

  // ---------------------------------------------------------------------
  // Per-bank state
  // ---------------------------------------------------------------------
  logic [MIDX_W-1:0]      rr_q      [NUM_BANKS];  // highest-priority master
  logic [MIDX_W-1:0]      owner_q   [NUM_BANKS];  // winner of previous cycle
  logic                   own_vld_q [NUM_BANKS];  // previous cycle was a grant

  // Arbitration results
  logic [NUM_MASTERS-1:0] cand      [NUM_BANKS];
  logic [MIDX_W-1:0]      win       [NUM_BANKS];
  logic                   has_win   [NUM_BANKS];
  logic                   fire      [NUM_BANKS];  // request accepted by bank

  // Round-robin: scan upward from rr_q, wrapping, take the first candidate.
  always_comb begin
    int idx;
    idx = 0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      cand[b]    = '0;
      win[b]     = '0;
      has_win[b] = 1'b0;
      for (int m = 0; m < NUM_MASTERS; m++) begin
        cand[b][m] = bus.master_req[m] && (bank_sel[m] == BANK_W'(b));
      end
      for (int k = 0; k < NUM_MASTERS; k++) begin
        idx = int'(rr_q[b]) + k;
        if (idx >= NUM_MASTERS) begin
          idx = idx - NUM_MASTERS;
        end
        if (!has_win[b] && cand[b][MIDX_W'(idx)]) begin
          has_win[b] = 1'b1;
          win[b]     = MIDX_W'(idx);
        end
      end
      // Reset forces every grant low regardless of what the bank drives.
      fire[b] = has_win[b] && bus.bank_gnt[b] && !rst_i;
    end
  end

  // Bank requests and master responses.
  always_comb begin
    bus.bank_req      = '0;
    bus.bank_we       = '0;
    bus.bank_addr     = '0;
    bus.bank_wdata    = '0;
    bus.bank_be       = '0;
    bus.master_gnt    = '0;
    bus.master_rvalid = '0;
    bus.master_rdata  = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (has_win[b] && !rst_i) begin
        bus.bank_req[b]   = 1'b1;
        bus.bank_we[b]    = bus.master_we[win[b]];
        bus.bank_addr[b]  = bus.master_addr[win[b]];
        bus.bank_wdata[b] = bus.master_wdata[win[b]];
        bus.bank_be[b]    = bus.master_be[win[b]];
      end
      if (fire[b]) begin
        bus.master_gnt[win[b]] = 1'b1;
      end
      // A master holds at most one grant per cycle, so at most one bank
      // can route a response to it; no collision handling is needed.
      if (bus.bank_rvalid[b] && own_vld_q[b] && !rst_i) begin
        bus.master_rvalid[owner_q[b]] = 1'b1;
        bus.master_rdata[owner_q[b]]  = bus.bank_rdata[b];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (rst_i) begin
        rr_q[b]      <= '0;
        owner_q[b]   <= '0;
        own_vld_q[b] <= 1'b0;
      end else begin
        owner_q[b]   <= win[b];
        own_vld_q[b] <= fire[b];
        if (fire[b]) begin
          rr_q[b] <= (win[b] == MIDX_W'(NUM_MASTERS - 1)) ? '0 : win[b] + 1'b1;
        end
      end
    end
  end

`ifdef OBI_ARB_CONFLICT_CNT_EN
  // ---------------------------------------------------------------------
  // Per-bank saturating conflict counters; clear wins over increment.
  // ---------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_cnt
    logic [CNT_W-1:0] cnt_q;
    logic             conflict;

    assign conflict = ($countones(cand[gi]) >= 2);

    always_ff @(posedge clk_i) begin
      if (rst_i || cnt_clear_i) begin
        cnt_q <= '0;
      end else if (conflict && !(&cnt_q)) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end

    assign conflict_cnt_o[gi*CNT_W +: CNT_W] = cnt_q;
  end
`endif

endmodule
